// File: rtl/menu_pkg.sv
// Shared constants, state encodings and navigation rules for the main-menu control stage.
package menu_pkg;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned META_W  = 26;
  localparam int unsigned MD_W    = 29;
  localparam int unsigned SEL_MSB = 28;
  localparam int unsigned SEL_LSB = 26;
  localparam int unsigned BTN_N   = 5;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_ENTER = 4;

  localparam logic [SEL_W-1:0] OPT_PLAY1P  = 3'd0;
  localparam logic [SEL_W-1:0] OPT_PLAYEND = 3'd1;
  localparam logic [SEL_W-1:0] OPT_PLAY2P  = 3'd2;
  localparam logic [SEL_W-1:0] OPT_TOP1P   = 3'd3;
  localparam logic [SEL_W-1:0] OPT_TOPEND  = 3'd4;

  typedef enum logic [1:0] {
    MENU   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } menu_state_e;

  typedef enum logic [2:0] {
    NAV_NONE  = 3'd0,
    NAV_UP    = 3'd1,
    NAV_DOWN  = 3'd2,
    NAV_LEFT  = 3'd3,
    NAV_RIGHT = 3'd4
  } nav_e;

  // Word handed to the VGA processor: cursor index above the pass-through bits.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [META_W-1:0] meta;
  } menu_meta_t;

  // Cursor move on the 3+2 option grid; columns wrap vertically, horizontal moves clamp.
  function automatic logic [SEL_W-1:0] nav_step(input logic [SEL_W-1:0] cur, input nav_e dir);
    logic [SEL_W-1:0] nxt;
    nxt = cur;
    case (dir)
      NAV_UP: begin
        case (cur)
          OPT_PLAY1P:  nxt = OPT_PLAY2P;
          OPT_PLAYEND: nxt = OPT_PLAY1P;
          OPT_PLAY2P:  nxt = OPT_PLAYEND;
          OPT_TOP1P:   nxt = OPT_TOPEND;
          OPT_TOPEND:  nxt = OPT_TOP1P;
          default:     nxt = OPT_PLAY1P;
        endcase
      end
      NAV_DOWN: begin
        case (cur)
          OPT_PLAY1P:  nxt = OPT_PLAYEND;
          OPT_PLAYEND: nxt = OPT_PLAY2P;
          OPT_PLAY2P:  nxt = OPT_PLAY1P;
          OPT_TOP1P:   nxt = OPT_TOPEND;
          OPT_TOPEND:  nxt = OPT_TOP1P;
          default:     nxt = OPT_PLAY1P;
        endcase
      end
      NAV_LEFT: begin
        case (cur)
          OPT_TOP1P:  nxt = OPT_PLAY1P;
          OPT_TOPEND: nxt = OPT_PLAYEND;
          default:    nxt = cur;
        endcase
      end
      NAV_RIGHT: begin
        case (cur)
          OPT_PLAY1P:  nxt = OPT_TOP1P;
          OPT_PLAYEND: nxt = OPT_TOPEND;
          OPT_PLAY2P:  nxt = OPT_TOPEND;
          default:     nxt = cur;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/menu_debounce.sv
// One button: 2-FF synchroniser, stability counter, and a single-cycle press pulse.
module menu_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             stable;
  logic             stable_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync        <= 2'b00;
      cnt         <= '0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync        <= {sync[0], raw};
      stable_prev <= stable;
      press       <= stable & ~stable_prev;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
      if (sync[1] != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/menu_select_ctrl.sv
// Main-menu cursor navigation and game-launch handshake feeding the menu VGA processor.
module menu_select_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_enter,
  input  logic [META_W-1:0] meta_in,
  input  logic              game_done,
  output logic [MD_W-1:0]   metadata,
  output logic              mode_valid,
  output logic [SEL_W-1:0]  mode_sel,
  output logic              locked
);

  logic [BTN_N-1:0] raw;
  logic [BTN_N-1:0] press;

  assign raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  for (genvar b = 0; b < BTN_N; b++) begin : g_btn
    menu_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clock (clock),
      .resetn(resetn),
      .raw   (raw[b]),
      .press (press[b])
    );
  end

  menu_state_e      state;
  menu_state_e      state_next;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] sel_next;
  logic             mode_valid_next;
  logic [SEL_W-1:0] mode_sel_next;
  logic             locked_next;
  nav_e             dir;
  menu_meta_t       meta_q;

  assign metadata = meta_q;

  // Fixed priority among navigation presses; ENTER outranks all of them in the FSM.
  always_comb begin
    dir = NAV_NONE;
    if (press[BTN_UP])         dir = NAV_UP;
    else if (press[BTN_DOWN])  dir = NAV_DOWN;
    else if (press[BTN_LEFT])  dir = NAV_LEFT;
    else if (press[BTN_RIGHT]) dir = NAV_RIGHT;
  end

  always_comb begin
    state_next      = state;
    sel_next        = sel;
    mode_valid_next = 1'b0;
    mode_sel_next   = mode_sel;
    locked_next     = 1'b0;
    case (state)
      MENU: begin
        if (press[BTN_ENTER]) state_next = LAUNCH;
        else                  sel_next   = nav_step(sel, dir);
      end
      LAUNCH:  state_next = RUN;
      RUN:     if (game_done) state_next = MENU;
      default: state_next = MENU;
    endcase
    // Scrub an upset cursor back to the first option.
    if (sel_next > OPT_TOPEND) sel_next = OPT_PLAY1P;
    mode_valid_next = (state_next == LAUNCH);
    if (mode_valid_next) mode_sel_next = sel_next;
    locked_next = (state_next == RUN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= MENU;
      sel        <= OPT_PLAY1P;
      meta_q     <= '0;
      mode_valid <= 1'b0;
      mode_sel   <= '0;
      locked     <= 1'b0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      meta_q.sel  <= sel;
      meta_q.meta <= meta_in;
      mode_valid  <= mode_valid_next;
      mode_sel    <= mode_sel_next;
      locked      <= locked_next;
    end
  end

endmodule
